cmp_result_tracker: RTL and testbench

//   Downstream consumer of the 3-bit magnitude comparator's l/g/e flags.
//   - Accepts one flag triple per valid cycle.
//   - Keeps saturating counts of less/greater/equal results.
//   - Runs an equality-lock FSM: locks after LOCK_N consecutive equals, unlocks after UNLOCK_M consecutive misses.
//   - Flags malformed (non-one-hot) triples. Outputs feed status/debug logic.

---
 rtl/cmp_result_tracker_if.sv | 29 ++
 rtl/cmp_result_tracker.sv | 135 +++++++++++++
 tb/tb_cmp_result_tracker.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cmp_result_tracker_if.sv
// Sample/result bundle between a comparator flag source and cmp_result_tracker.
// The master drives the flags and clr. The slave returns the counts, lock state and error.
interface cmp_result_tracker_if #(
  parameter int CNT_W = 8
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic             l;
  logic             g;
  logic             e;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic             locked;
  logic             lock_pulse;
  logic             unlock_pulse;
  logic             err;

  modport master (
    output clr, in_valid, l, g, e,
    input  in_ready, lt_cnt, gt_cnt, eq_cnt, locked, lock_pulse, unlock_pulse, err
  );

  modport slave (
    input  clr, in_valid, l, g, e,
    output in_ready, lt_cnt, gt_cnt, eq_cnt, locked, lock_pulse, unlock_pulse, err
  );
endinterface

// File: rtl/cmp_result_tracker.sv
// Consumes l/g/e comparator flags: saturating per-result counters, sticky malformed flag,
// and a SEARCH/LOCKED equality-lock FSM with registered transition pulses.
module cmp_result_tracker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_M = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmp_result_tracker_if.slave   bus
);
  localparam int RUN_MAX = (LOCK_N > UNLOCK_M) ? LOCK_N : UNLOCK_M;
  localparam int RW      = $clog2(RUN_MAX + 1);

  localparam logic [RW-1:0]    RUN_ONE  = RW'(1);
  localparam logic [RW-1:0]    LOCK_V   = RW'(LOCK_N);
  localparam logic [RW-1:0]    UNLOCK_V = RW'(UNLOCK_M);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    run_q, run_d, run_inc;
  logic             lock_pulse_q, lock_pulse_d;
  logic             unlock_pulse_q, unlock_pulse_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;

  logic accept, is_lt, is_gt, is_eq, is_bad;

  assign bus.in_ready = ~bus.clr;
  assign accept       = bus.in_valid & ~bus.clr;

  assign is_lt  = ({bus.l, bus.g, bus.e} == 3'b100);
  assign is_gt  = ({bus.l, bus.g, bus.e} == 3'b010);
  assign is_eq  = ({bus.l, bus.g, bus.e} == 3'b001);
  assign is_bad = ~(is_lt | is_gt | is_eq);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    return (hit && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  // State/run register; run_q only ever reaches the active threshold minus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next state: clr wins over any sample, idle cycles hold everything.
  always_comb begin
    state_d        = state_q;
    run_d          = run_q;
    lock_pulse_d   = 1'b0;
    unlock_pulse_d = 1'b0;
    run_inc        = run_q + RUN_ONE;
    if (bus.clr) begin
      state_d = SEARCH;
      run_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        SEARCH: begin
          if (!is_eq)                  run_d = '0;
          else if (run_inc == LOCK_V) begin
            state_d      = LOCKED;
            run_d        = '0;
            lock_pulse_d = 1'b1;
          end else                     run_d = run_inc;
        end
        LOCKED: begin
          if (is_eq)                     run_d = '0;
          else if (run_inc == UNLOCK_V) begin
            state_d        = SEARCH;
            run_d          = '0;
            unlock_pulse_d = 1'b1;
          end else                       run_d = run_inc;
        end
        default: begin
          state_d = SEARCH;
          run_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    lt_d  = lt_q;
    gt_d  = gt_q;
    eq_d  = eq_q;
    err_d = err_q;
    if (bus.clr) begin
      lt_d  = '0;
      gt_d  = '0;
      eq_d  = '0;
      err_d = 1'b0;
    end else if (accept) begin
      lt_d  = sat_inc(lt_q, is_lt);
      gt_d  = sat_inc(gt_q, is_gt);
      eq_d  = sat_inc(eq_q, is_eq);
      err_d = err_q | is_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_q           <= '0;
      gt_q           <= '0;
      eq_q           <= '0;
      err_q          <= 1'b0;
      lock_pulse_q   <= 1'b0;
      unlock_pulse_q <= 1'b0;
    end else begin
      lt_q           <= lt_d;
      gt_q           <= gt_d;
      eq_q           <= eq_d;
      err_q          <= err_d;
      lock_pulse_q   <= lock_pulse_d;
      unlock_pulse_q <= unlock_pulse_d;
    end
  end

  always_comb begin
    bus.lt_cnt       = lt_q;
    bus.gt_cnt       = gt_q;
    bus.eq_cnt       = eq_q;
    bus.err          = err_q;
    bus.locked       = (state_q == LOCKED);
    bus.lock_pulse   = lock_pulse_q;
    bus.unlock_pulse = unlock_pulse_q;
  end
endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a history-based model.
module tb_cmp_result_tracker;
  localparam int CNT_W    = 3;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_M = 2;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_result_tracker_if #(.CNT_W(CNT_W)) bus ();

  cmp_result_tracker #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .UNLOCK_M(UNLOCK_M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counts as plain ints, and lock decisions made by scanning the samples
  // accepted since the last lock/unlock (or clear) for the trailing run that matters.
  int m_lt = 0, m_gt = 0, m_eq = 0;
  bit m_err = 0, m_locked = 0, m_lp = 0, m_up = 0;
  bit hist[$];

  task automatic model_reset();
    m_lt = 0; m_gt = 0; m_eq = 0;
    m_err = 0; m_locked = 0; m_lp = 0; m_up = 0;
    hist.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_lp = 0;
      m_up = 0;
      if (bus.clr) begin
        model_reset();
      end else if (bus.in_valid) begin
        logic [2:0] t;
        int tail, need;
        bit want;
        t = {bus.l, bus.g, bus.e};
        if      (t == 3'b100) m_lt = (m_lt < CMAX) ? m_lt + 1 : CMAX;
        else if (t == 3'b010) m_gt = (m_gt < CMAX) ? m_gt + 1 : CMAX;
        else if (t == 3'b001) m_eq = (m_eq < CMAX) ? m_eq + 1 : CMAX;
        else                  m_err = 1;
        hist.push_back(t == 3'b001);
        want = !m_locked;
        need = m_locked ? UNLOCK_M : LOCK_N;
        tail = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == want; i--) tail++;
        if (tail >= need) begin
          if (m_locked) m_up = 1; else m_lp = 1;
          m_locked = !m_locked;
          hist.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [13:0] got, exp;
    got = {bus.in_ready, bus.lt_cnt, bus.gt_cnt, bus.eq_cnt,
           bus.locked, bus.lock_pulse, bus.unlock_pulse, bus.err};
    exp = {~bus.clr, CNT_W'(m_lt), CNT_W'(m_gt), CNT_W'(m_eq),
           m_locked, m_lp, m_up, m_err};
    chk("cycle", 32'(got), 32'(exp));
  end

  task automatic send(input logic v, input logic [2:0] t);
    bus.in_valid = v;
    {bus.l, bus.g, bus.e} = t;
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    bus.clr = 1'b0;
    bus.in_valid = 1'b1;
    {bus.l, bus.g, bus.e} = 3'b001;

    // reset held with valid EQ traffic presented
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eq_cnt", 32'(bus.eq_cnt), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // lock then unlock
    repeat (4) send(1'b1, 3'b001);
    chk("lock_eq4", 32'(bus.eq_cnt), 4);
    chk("lock_pulse", 32'(bus.lock_pulse), 1);
    chk("lock_locked", 32'(bus.locked), 1);
    send(1'b1, 3'b001);
    chk("lock_pulse_gone", 32'(bus.lock_pulse), 0);
    send(1'b1, 3'b010);
    send(1'b1, 3'b001);
    send(1'b1, 3'b010);
    chk("still_locked", 32'(bus.locked), 1);
    send(1'b1, 3'b010);
    chk("unlock_pulse", 32'(bus.unlock_pulse), 1);
    chk("unlock_locked", 32'(bus.locked), 0);
    chk("unlock_gt3", 32'(bus.gt_cnt), 3);
    send(1'b0, 3'b000);
    chk("unlock_pulse_gone", 32'(bus.unlock_pulse), 0);

    // saturation
    do_clr();
    for (int i = 1; i <= 10; i++) begin
      send(1'b1, 3'b100);
      chk("sat_lt", 32'(bus.lt_cnt), 32'((i < CMAX) ? i : CMAX));
    end
    chk("sat_gt0", 32'(bus.gt_cnt), 0);
    chk("sat_eq0", 32'(bus.eq_cnt), 0);

    // malformed triple breaks the equal run
    do_clr();
    repeat (3) send(1'b1, 3'b001);
    send(1'b1, 3'b011);
    chk("bad_err", 32'(bus.err), 1);
    chk("bad_eq", 32'(bus.eq_cnt), 3);
    chk("bad_lt", 32'(bus.lt_cnt), 0);
    chk("bad_gt", 32'(bus.gt_cnt), 0);
    repeat (3) send(1'b1, 3'b001);
    chk("bad_not_locked", 32'(bus.locked), 0);
    send(1'b1, 3'b001);
    chk("bad_relock", 32'(bus.locked), 1);
    chk("bad_err_sticky", 32'(bus.err), 1);

    // clr while locked with a sample presented
    bus.clr = 1'b1;
    bus.in_valid = 1'b1;
    {bus.l, bus.g, bus.e} = 3'b001;
    #1;
    chk("clr_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_eq", 32'(bus.eq_cnt), 0);
    chk("clr_locked", 32'(bus.locked), 0);
    chk("clr_pulses", 32'({bus.lock_pulse, bus.unlock_pulse}), 0);
    chk("clr_err", 32'(bus.err), 0);

    // equal samples separated by idle cycles
    for (int k = 0; k < LOCK_N; k++) begin
      send(1'b1, 3'b001);
      chk("gap_locked", 32'(bus.locked), 32'(k == LOCK_N - 1));
      repeat (3) send(1'b0, 3'b010);
    end

    // async reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_locked", 32'(bus.locked), 0);
    chk("async_rst_eq", 32'(bus.eq_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic [2:0] t;
      bus.clr = ($urandom_range(0, 99) < 3);
      r = $urandom_range(0, 9);
      if (r < 5)      t = 3'b001;
      else if (r < 7) t = 3'b100;
      else if (r < 8) t = 3'b010;
      else            t = 3'($urandom_range(0, 7));
      bus.in_valid = ($urandom_range(0, 99) < 75);
      {bus.l, bus.g, bus.e} = t;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
